ex_ma_pipe_reg: RTL and testbench

Parametrised EX→MA pipeline register with a valid/ready handshake, stall hold, flush-to-bubble and an optional 2-entry skid buffer. It sits between the execute stage and the memory-access stage. It latches PC, ALU result, store operand, instruction, control word, branch target, branch-taken and flags. Compared with the plain always-load latch, it can hold its contents under downstream stall, kill in-flight entries on a flush, and reset the instruction field to a NOP.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_skid_buf.sv | 112 +++++++++++
 rtl/ex_ma_pipe_reg.sv | 83 ++++++++
 tb/tb_ex_ma_pipe_reg.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared types and constants for pipeline-stage registers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h6800_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  // pc, alu, op2, inst and branch_pc are each DATA_W wide
  function automatic int payload_w(input int dw, input int cw, input int fw);
    return 5 * dw + cw + 1 + fw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_skid_buf.sv
// ============================================================================
// Module : pipe_skid_buf
// Brief  : Valid/ready holding register with optional skid slot and flush.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int             W       = 8,
  parameter bit             SKID_EN = 1'b1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_occupancy
);

  pipe_state_e  r_state;
  pipe_state_e  w_state_nxt;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic         w_accept;
  logic         w_pop;
  logic         w_load_head;
  logic         w_load_skid;
  logic         w_head_from_skid;

  assign o_valid = (r_state != ST_EMPTY);
  assign o_data  = r_head;

  generate
    if (SKID_EN) begin : g_skid_ready
      // Derived from state only, so no path from i_ready to o_ready
      assign o_ready = (r_state != ST_TWO);
    end else begin : g_bypass_ready
      assign o_ready = !o_valid || i_ready;
    end
  endgenerate

  assign w_accept = i_valid && o_ready && !i_flush;
  assign w_pop    = o_valid && i_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_head      = 1'b0;
    w_load_skid      = 1'b0;
    w_head_from_skid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_load_head = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_pop) begin
          w_load_head = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_TWO;
          w_load_skid = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_state_nxt      = ST_ONE;
          w_head_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    case (r_state)
      ST_ONE:  o_occupancy = 2'd1;
      ST_TWO:  o_occupancy = 2'd2;
      default: o_occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_state <= ST_EMPTY;
      r_head  <= RST_VAL;
      r_skid  <= RST_VAL;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_head) begin
        r_head <= i_data;
      end else if (w_head_from_skid) begin
        r_head <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= i_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_ma_pipe_reg.sv
// ============================================================================
// Module : ex_ma_pipe_reg
// Brief  : EX->MA pipeline register with handshake, stall, flush and skid.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_ma_pipe_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 22,
  parameter int                FLAG_W   = 4,
  parameter bit                SKID_EN  = 1'b1,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] op2_in,
  input  logic [DATA_W-1:0] inst_in,
  input  logic [DATA_W-1:0] branch_pc_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              br_taken_in,
  input  logic [FLAG_W-1:0] flags_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] op2_out,
  output logic [DATA_W-1:0] inst_out,
  output logic [DATA_W-1:0] branch_pc_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              br_taken_out,
  output logic [FLAG_W-1:0] flags_out,
  output logic [1:0]        occupancy
);

  localparam int c_PW = payload_w(DATA_W, CTRL_W, FLAG_W);

  // Reset/flush image: every field zero except the instruction slot
  localparam logic [c_PW-1:0] c_RST_VAL =
    {{(3 * DATA_W){1'b0}}, NOP_INST, {(DATA_W + CTRL_W + 1 + FLAG_W){1'b0}}};

  logic [c_PW-1:0]   w_pack_in;
  logic [c_PW-1:0]   w_pack_out;
  logic [CTRL_W-1:0] w_ctrl_head;
  logic              w_br_head;

  assign w_pack_in = {pc_in, alu_in, op2_in, inst_in, branch_pc_in,
                      ctrl_in, br_taken_in, flags_in};

  pipe_skid_buf #(
    .W       (c_PW),
    .SKID_EN (SKID_EN),
    .RST_VAL (c_RST_VAL)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_valid     (valid_in),
    .i_data      (w_pack_in),
    .o_ready     (ready_out),
    .i_ready     (ready_in),
    .o_valid     (valid_out),
    .o_data      (w_pack_out),
    .o_occupancy (occupancy)
  );

  assign {pc_out, alu_out, op2_out, inst_out, branch_pc_out,
          w_ctrl_head, w_br_head, flags_out} = w_pack_out;

  // MA must see a clean bubble whenever nothing is valid
  assign ctrl_out     = valid_out ? w_ctrl_head : '0;
  assign br_taken_out = valid_out & w_br_head;

endmodule

`default_nettype wire

// File: tb/tb_ex_ma_pipe_reg.sv
// ============================================================================
// Module : tb_ex_ma_pipe_reg
// Brief  : Queue-model bench for ex_ma_pipe_reg, skid and no-skid builds.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_ma_pipe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] op2;
    logic [31:0] inst;
    logic [31:0] bpc;
    logic [21:0] ctrl;
    logic        br;
    logic [3:0]  flags;
  } pay_t;

  localparam logic [31:0] c_NOP = 32'h6800_0000;

  logic clk = 1'b0;
  logic rst, flush, valid_in, ready_in;
  pay_t in_p;

  logic        ready_out [2];
  logic        valid_out [2];
  logic [31:0] pc_out [2], alu_out [2], op2_out [2], inst_out [2], bpc_out [2];
  logic [21:0] ctrl_out [2];
  logic        br_out [2];
  logic [3:0]  flags_out [2];
  logic [1:0]  occ [2];

  int n_tests = 0;
  int n_fail  = 0;

  pay_t m_e [2][2];
  int   m_n [2];
  pay_t m_disp [2];
  bit   started = 1'b0;

  always #5 clk = ~clk;

  ex_ma_pipe_reg #(.SKID_EN(1'b1)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .ready_out(ready_out[0]),
    .pc_in(in_p.pc), .alu_in(in_p.alu), .op2_in(in_p.op2), .inst_in(in_p.inst),
    .branch_pc_in(in_p.bpc), .ctrl_in(in_p.ctrl), .br_taken_in(in_p.br), .flags_in(in_p.flags),
    .valid_out(valid_out[0]), .ready_in(ready_in),
    .pc_out(pc_out[0]), .alu_out(alu_out[0]), .op2_out(op2_out[0]), .inst_out(inst_out[0]),
    .branch_pc_out(bpc_out[0]), .ctrl_out(ctrl_out[0]), .br_taken_out(br_out[0]),
    .flags_out(flags_out[0]), .occupancy(occ[0])
  );

  ex_ma_pipe_reg #(.SKID_EN(1'b0)) dut_noskid (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .ready_out(ready_out[1]),
    .pc_in(in_p.pc), .alu_in(in_p.alu), .op2_in(in_p.op2), .inst_in(in_p.inst),
    .branch_pc_in(in_p.bpc), .ctrl_in(in_p.ctrl), .br_taken_in(in_p.br), .flags_in(in_p.flags),
    .valid_out(valid_out[1]), .ready_in(ready_in),
    .pc_out(pc_out[1]), .alu_out(alu_out[1]), .op2_out(op2_out[1]), .inst_out(inst_out[1]),
    .branch_pc_out(bpc_out[1]), .ctrl_out(ctrl_out[1]), .br_taken_out(br_out[1]),
    .flags_out(flags_out[1]), .occupancy(occ[1])
  );

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] at %0t: got %0h, expected %0h", nm, k, $time, act, exp);
    end
  endtask

  function automatic pay_t mk(input logic [31:0] pc, input bit ctrl_all_ones);
    pay_t p;
    p.pc    = pc;
    p.alu   = pc ^ 32'hA5A5_0000;
    p.op2   = pc + 32'd1;
    p.inst  = {pc[15:0], 16'h0013};
    p.bpc   = pc + 32'h40;
    p.ctrl  = ctrl_all_ones ? 22'h3F_FFFF : pc[21:0];
    p.br    = pc[2];
    p.flags = pc[5:2];
    return p;
  endfunction

  function automatic pay_t rst_img();
    pay_t p;
    p      = '0;
    p.inst = c_NOP;
    return p;
  endfunction

  // Capacity-limited FIFO: 2 entries with skid, 1 entry without
  function automatic bit exp_ready(input int k);
    return (k == 0) ? (m_n[k] < 2) : (m_n[k] == 0 || ready_in);
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit rdy, pop, acc;
      rdy = exp_ready(k);
      pop = (m_n[k] > 0) && ready_in;
      acc = valid_in && rdy && !flush;
      if (rst || flush) begin
        m_n[k]    = 0;
        m_disp[k] = rst_img();
      end else begin
        if (pop) begin
          m_e[k][0] = m_e[k][1];
          m_n[k]    = m_n[k] - 1;
        end
        if (acc) begin
          m_e[k][m_n[k]] = in_p;
          m_n[k]         = m_n[k] + 1;
        end
        if (m_n[k] > 0) m_disp[k] = m_e[k][0];
      end
    end
    started = 1'b1;
  endtask

  task automatic cyc(input bit r, input bit f, input bit v, input logic [31:0] pc,
                     input bit rdy, input bit ctrl_ones);
    rst      = r;
    flush    = f;
    valid_in = v;
    ready_in = rdy;
    in_p     = r ? pay_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom})
                 : mk(pc, ctrl_ones);
    @(posedge clk);
    model_step();
    #2;
  endtask

  initial begin
    wait (started);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        bit v;
        v = (m_n[k] > 0);
        chk("valid_out", k, 64'(valid_out[k]), 64'(v));
        chk("occupancy", k, 64'(occ[k]), 64'(m_n[k]));
        chk("ready_out", k, 64'(ready_out[k]), 64'(exp_ready(k)));
        chk("ctrl_out", k, 64'(ctrl_out[k]), v ? 64'(m_disp[k].ctrl) : 64'd0);
        chk("br_taken_out", k, 64'(br_out[k]), v ? 64'(m_disp[k].br) : 64'd0);
        chk("pc_out", k, 64'(pc_out[k]), 64'(m_disp[k].pc));
        chk("alu_out", k, 64'(alu_out[k]), 64'(m_disp[k].alu));
        chk("op2_out", k, 64'(op2_out[k]), 64'(m_disp[k].op2));
        chk("inst_out", k, 64'(inst_out[k]), 64'(m_disp[k].inst));
        chk("branch_pc_out", k, 64'(bpc_out[k]), 64'(m_disp[k].bpc));
        chk("flags_out", k, 64'(flags_out[k]), 64'(m_disp[k].flags));
      end
    end
  end

  initial begin
    m_n[0] = 0;
    m_n[1] = 0;
    m_disp[0] = rst_img();
    m_disp[1] = rst_img();

    // Reset with random inputs
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      chk("lit_rst_valid", k, 64'(valid_out[k]), 64'd0);
      chk("lit_rst_inst", k, 64'(inst_out[k]), 64'h6800_0000);
      chk("lit_rst_pc", k, 64'(pc_out[k]), 64'd0);
      chk("lit_rst_occ", k, 64'(occ[k]), 64'd0);
    end
    cyc(0, 0, 0, 0, 1, 0);
    chk("lit_rdy_after_rst", 0, 64'(ready_out[0]), 64'd1);

    // Streaming at one entry per cycle
    cyc(0, 0, 1, 32'h100, 1, 0);
    chk("lit_stream0", 0, 64'(pc_out[0]), 64'h100);
    cyc(0, 0, 1, 32'h104, 1, 0);
    chk("lit_stream1", 0, 64'(pc_out[0]), 64'h104);
    chk("lit_stream1", 1, 64'(pc_out[1]), 64'h104);
    cyc(0, 0, 1, 32'h108, 1, 0);
    chk("lit_stream2", 0, 64'(pc_out[0]), 64'h108);
    chk("lit_stream2_valid", 1, 64'(valid_out[1]), 64'd1);
    cyc(0, 0, 0, 0, 1, 0);

    // Stall: skid build absorbs 0x204, no-skid build refuses it
    cyc(0, 0, 1, 32'h200, 0, 0);
    cyc(0, 0, 1, 32'h204, 0, 1);
    cyc(0, 0, 1, 32'h204, 0, 1);
    chk("lit_stall_occ", 0, 64'(occ[0]), 64'd2);
    chk("lit_stall_rdy", 0, 64'(ready_out[0]), 64'd0);
    chk("lit_stall_pc", 0, 64'(pc_out[0]), 64'h200);
    chk("lit_noskid_rdy", 1, 64'(ready_out[1]), 64'd0);
    chk("lit_noskid_ctrl", 1, 64'(ctrl_out[1]), 64'h200);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_stall_hold", 0, 64'(pc_out[0]), 64'h200);
    cyc(0, 0, 0, 0, 1, 0);
    chk("lit_release", 0, 64'(pc_out[0]), 64'h204);
    chk("lit_release_occ", 0, 64'(occ[0]), 64'd1);
    cyc(0, 0, 0, 0, 1, 0);

    // Flush in TWO together with an incoming entry
    cyc(0, 0, 1, 32'h280, 0, 0);
    cyc(0, 0, 1, 32'h284, 0, 0);
    chk("lit_pre_flush_occ", 0, 64'(occ[0]), 64'd2);
    cyc(0, 1, 1, 32'h300, 0, 1);
    for (int k = 0; k < 2; k++) begin
      chk("lit_flush_valid", k, 64'(valid_out[k]), 64'd0);
      chk("lit_flush_ctrl", k, 64'(ctrl_out[k]), 64'd0);
      chk("lit_flush_inst", k, 64'(inst_out[k]), 64'h6800_0000);
      chk("lit_flush_occ", k, 64'(occ[k]), 64'd0);
    end
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("lit_flush_dropped", 0, 64'(valid_out[0]), 64'd0);

    // Mixed valid/ready pattern
    for (int i = 0; i < 24; i++) begin
      cyc(0, 0, (i % 4) != 1, 32'h500 + 32'(4 * i), (i % 3) != 0, 0);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);

    // Reset mid-stall in TWO
    cyc(0, 0, 1, 32'h404, 0, 0);
    cyc(0, 0, 1, 32'h408, 0, 0);
    chk("lit_pre_rst_br", 0, 64'(br_out[0]), 64'd1);
    chk("lit_pre_rst_flags", 0, 64'(flags_out[0]), 64'd1);
    cyc(1, 0, 1, 0, 0, 0);
    chk("lit_midrst_occ", 0, 64'(occ[0]), 64'd0);
    chk("lit_midrst_br", 0, 64'(br_out[0]), 64'd0);
    chk("lit_midrst_flags", 0, 64'(flags_out[0]), 64'd0);
    chk("lit_midrst_valid", 0, 64'(valid_out[0]), 64'd0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
